// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store unit, one word-aligned req/gnt/rvalid transaction at a time.
// Latency: store accept->wb_valid 2 cycles, load 3 cycles, +1 per gnt/rvalid wait; illegal op 1 cycle.
// Backpressure: ex_ready high only in IDLE; mem_req held with stable fields until mem_gnt.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   ex_valid/ex_ready               EX handshake; ex_is_store, ex_funct3, ex_addr, ex_wdata, ex_rd op fields
//   flush                           kill the in-flight op (branch/jump redirect)
//   mem_req/mem_gnt, mem_we, mem_be, mem_addr, mem_wdata   data-memory request channel
//   mem_rvalid, mem_rdata           data-memory read response
//   wb_valid, wb_we, wb_rd, wb_data, wb_err                  one-cycle writeback pulse
//
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses
// (no bus request, wb_err=1). Undefined: offending low address bits are ignored.

module lsu_ctrl #(
  parameter int DataWidth = 32,
  parameter int RegAddrW  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic                 ex_is_store,
  input  logic [2:0]           ex_funct3,
  input  logic [DataWidth-1:0] ex_addr,
  input  logic [DataWidth-1:0] ex_wdata,
  input  logic [RegAddrW-1:0]  ex_rd,
  input  logic                 flush,
  output logic                 mem_req,
  input  logic                 mem_gnt,
  output logic                 mem_we,
  output logic [3:0]           mem_be,
  output logic [DataWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic                 mem_rvalid,
  input  logic [DataWidth-1:0] mem_rdata,
  output logic                 wb_valid,
  output logic                 wb_we,
  output logic [RegAddrW-1:0]  wb_rd,
  output logic [DataWidth-1:0] wb_data,
  output logic                 wb_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched op
  logic                 op_store_q;
  logic [2:0]           op_f3_q;
  logic [DataWidth-1:0] op_addr_q;
  logic [DataWidth-1:0] op_wdata_q;
  logic [RegAddrW-1:0]  op_rd_q;
  logic                 err_q;   // op completes with wb_err, never touches the bus
  logic                 kill_q;  // flushed after grant: finish the bus response, drop writeback
  logic [DataWidth-1:0] rdata_q; // extended load result (stays 0 for stores)

  // FSM control strobes
  logic latch;
  logic capture;
  logic set_kill;

  // ---------------------------------------------------------------------------
  // Decode of the op presented by EX (evaluated at acceptance)
  // ---------------------------------------------------------------------------
  logic ex_legal;
  logic ex_misalign_trap;
  logic ex_err;

  always_comb begin
    ex_legal = 1'b0;
    if (ex_is_store) begin
      ex_legal = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010);
    end else begin
      ex_legal = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010) ||
                 (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    ex_misalign_trap = 1'b0;
    if (ex_funct3[1:0] == 2'b01) begin
      ex_misalign_trap = ex_addr[0];
    end else if (ex_funct3[1:0] == 2'b10) begin
      ex_misalign_trap = (ex_addr[1:0] != 2'b00);
    end
  end
`else
  assign ex_misalign_trap = 1'b0;
`endif

  assign ex_err = !ex_legal || ex_misalign_trap;

  // ---------------------------------------------------------------------------
  // Next-state / control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    ex_ready = 1'b0;
    mem_req  = 1'b0;
    wb_valid = 1'b0;
    latch    = 1'b0;
    capture  = 1'b0;
    set_kill = 1'b0;
    case (state_q)
      S_IDLE: begin
        ex_ready = 1'b1;
        // flush in IDLE blocks acceptance for that cycle
        if (ex_valid && !flush) begin
          latch   = 1'b1;
          state_d = ex_err ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          // Granted: the transaction is committed on the bus even if flushed now
          set_kill = flush;
          state_d  = op_store_q ? S_DONE : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        set_kill = flush;
        if (mem_rvalid) begin
          capture = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        wb_valid = !kill_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load data extraction from the returned word
  // ---------------------------------------------------------------------------
  logic [DataWidth-1:0] rd_shift;
  logic [7:0]           rd_byte;
  logic [15:0]          rd_half;
  logic [DataWidth-1:0] rd_ext;

  assign rd_shift = mem_rdata >> {op_addr_q[1:0], 3'b000};
  assign rd_byte  = rd_shift[7:0];
  // Halfword lane chosen by a[1] only; a[0] is ignored when not trapping
  assign rd_half  = op_addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    rd_ext = '0;
    case (op_f3_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b010:  rd_ext = mem_rdata;
      3'b100:  rd_ext = {24'd0, rd_byte};
      3'b101:  rd_ext = {16'd0, rd_half};
      default: rd_ext = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and op registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_store_q <= 1'b0;
      op_f3_q    <= 3'b000;
      op_addr_q  <= '0;
      op_wdata_q <= '0;
      op_rd_q    <= '0;
      err_q      <= 1'b0;
      kill_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        op_store_q <= ex_is_store;
        op_f3_q    <= ex_funct3;
        op_addr_q  <= ex_addr;
        op_wdata_q <= ex_wdata;
        op_rd_q    <= ex_rd;
        err_q      <= ex_err;
        kill_q     <= 1'b0;
        rdata_q    <= '0;
      end
      if (set_kill) begin
        kill_q <= 1'b1;
      end
      if (capture) begin
        rdata_q <= rd_ext;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus request fields, driven only while requesting
  // ---------------------------------------------------------------------------
  logic [3:0]           be_c;
  logic [DataWidth-1:0] wdata_c;

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = op_wdata_q;
    case (op_f3_q[1:0])
      2'b00: begin
        be_c    = 4'b0001 << op_addr_q[1:0];
        wdata_c = {4{op_wdata_q[7:0]}};
      end
      2'b01: begin
        be_c    = op_addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{op_wdata_q[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = op_wdata_q;
      end
    endcase
  end

  assign mem_we    = mem_req & op_store_q;
  assign mem_be    = mem_req ? be_c : 4'b0000;
  assign mem_addr  = mem_req ? {op_addr_q[DataWidth-1:2], 2'b00} : '0;
  assign mem_wdata = mem_req ? wdata_c : '0;

  // ---------------------------------------------------------------------------
  // Writeback, qualified by the completion pulse
  // ---------------------------------------------------------------------------
  assign wb_we   = wb_valid & ~op_store_q & ~err_q;
  assign wb_rd   = wb_valid ? op_rd_q : '0;
  assign wb_data = wb_valid ? rdata_q : '0;
  assign wb_err  = wb_valid & err_q;

endmodule
